// File: rtl/moore_pkg.sv
// Shared constants and elaboration-time helpers for the Moore pattern detector.
// Optional match counter is enabled by defining MOORE_MATCH_COUNT_EN.
package moore_pkg;

   localparam int         DEF_PAT_LEN = 4;
   localparam logic [3:0] DEF_PATTERN = 4'b1010;
   localparam int         TBL_W       = 320;

   function automatic int state_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Longest pattern prefix that is a suffix of (first k pattern bits + b).
   function automatic int kmp_next(
      input logic [15:0] pat,
      input int          len,
      input bit          ovl,
      input int          k,
      input logic        b
   );
      int          kk;
      int          best;
      bit          ok;
      logic [16:0] s;
      kk   = (k == len && !ovl) ? 0 : k;
      s    = '0;
      best = 0;
      for (int i = 0; i < kk; i++) s[i] = pat[len-1-i];
      s[kk] = b;
      for (int l = 1; l <= len; l++) begin
         if (l <= kk + 1) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++)
               if (s[kk+1-l+j] != pat[len-1-j]) ok = 1'b0;
            if (ok) best = l;
         end
      end
      return best;
   endfunction

   // Entry {state,inbit} holds sw bits; states above len stay 0.
   function automatic logic [TBL_W-1:0] kmp_table(
      input logic [15:0] pat,
      input int          len,
      input bit          ovl,
      input int          sw
   );
      logic [TBL_W-1:0] t;
      int               n;
      t = '0;
      for (int k = 0; k <= len; k++) begin
         for (int b = 0; b < 2; b++) begin
            n = kmp_next(pat, len, ovl, k, b[0]);
            for (int i = 0; i < sw; i++)
               t[(2*k+b)*sw+i] = n[i];
         end
      end
      return t;
   endfunction

endpackage

// File: rtl/moore_detector_next_state.sv
// Combinational next-state lookup for the Moore detector.
// Uses a KMP fallback table folded into a constant at elaboration.
module moore_next_state
   import moore_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
   parameter bit                 OVERLAP = 1'b1
) (
   input  logic [state_w(PAT_LEN)-1:0] i_state,
   input  logic                        i_inbit,
   output logic [state_w(PAT_LEN)-1:0] o_next
);

   localparam int SW = state_w(PAT_LEN);
   localparam logic [TBL_W-1:0] TBL =
      kmp_table(16'(PATTERN), PAT_LEN, OVERLAP, SW);

   always_comb begin
      o_next = '0;
      o_next = TBL[int'({i_state, i_inbit}) * SW +: SW];
   end

endmodule

// File: rtl/moore_detector.sv
// Moore serial pattern detector: state register, detect decode, optional counter.
// Define MOORE_MATCH_COUNT_EN to add the saturating match_count output.
module moore_detector
   import moore_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
   parameter bit                 OVERLAP = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inbit,
`ifdef MOORE_MATCH_COUNT_EN
   output logic [15:0] match_count,
`endif
   output logic        detect
);

   localparam int            SW   = state_w(PAT_LEN);
   localparam logic [SW-1:0] LAST = SW'(PAT_LEN);

   logic [SW-1:0] r_state;
   logic [SW-1:0] w_next;

   moore_next_state #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN),
      .OVERLAP (OVERLAP)
   ) u_next (
      .i_state (r_state),
      .i_inbit (inbit),
      .o_next  (w_next)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= '0;
      else       r_state <= w_next;
   end

   assign detect = (r_state == LAST);

`ifdef MOORE_MATCH_COUNT_EN
   logic [15:0] r_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_count <= '0;
      else if (w_next == LAST && r_count != 16'hFFFF)
         r_count <= r_count + 16'd1;
   end

   assign match_count = r_count;
`else
`endif

endmodule

// File: tb/tb_moore_detector.sv
// Directed bench: default 1010 overlap, 1010 non-overlap and 111 overlap
// detectors share one stimulus stream and are checked bit by bit.
module tb_moore_detector;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic inbit = 1'b0;
   logic det_ov, det_no, det_one;
   int   n_chk = 0;
   int   n_fail = 0;

`ifdef MOORE_MATCH_COUNT_EN
   logic [15:0] mc_ov, mc_no, mc_one;
`endif

   always #5 clk = ~clk;

   moore_detector dut_ov (
      .clk         (clk),
      .reset       (reset),
      .inbit       (inbit),
`ifdef MOORE_MATCH_COUNT_EN
      .match_count (mc_ov),
`endif
      .detect      (det_ov)
   );

   moore_detector #(
      .PAT_LEN (4),
      .PATTERN (4'b1010),
      .OVERLAP (1'b0)
   ) dut_no (
      .clk         (clk),
      .reset       (reset),
      .inbit       (inbit),
`ifdef MOORE_MATCH_COUNT_EN
      .match_count (mc_no),
`endif
      .detect      (det_no)
   );

   moore_detector #(
      .PAT_LEN (3),
      .PATTERN (3'b111),
      .OVERLAP (1'b1)
   ) dut_one (
      .clk         (clk),
      .reset       (reset),
      .inbit       (inbit),
`ifdef MOORE_MATCH_COUNT_EN
      .match_count (mc_one),
`endif
      .detect      (det_one)
   );

   task automatic chk(input string tag, input int idx,
                      input logic got, input logic exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d]: observed %b expected %b",
                tag, idx, got, exp);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         inbit = i[0];
         @(posedge clk);
         #1;
         chk("rst_ov", i, det_ov, 1'b0);
         chk("rst_no", i, det_no, 1'b0);
         chk("rst_one", i, det_one, 1'b0);
      end
      reset = 1'b0;
   endtask

   // bits/e* are MSB-first: bit n-1 is the first one driven.
   task automatic run(input string tag, input int n,
                      input logic [31:0] bits,
                      input logic [31:0] e_ov,
                      input logic [31:0] e_no,
                      input logic [31:0] e_one);
      for (int i = 0; i < n; i++) begin
         inbit = bits[n-1-i];
         @(posedge clk);
         #1;
         chk({tag, "_ov"}, i + 1, det_ov, e_ov[n-1-i]);
         chk({tag, "_no"}, i + 1, det_no, e_no[n-1-i]);
         chk({tag, "_one"}, i + 1, det_one, e_one[n-1-i]);
      end
   endtask

   initial begin
      do_reset(2);

      run("ovl", 8, 32'b10101010,
          32'b00010101, 32'b00010001, 32'b0);

      do_reset(1);
      run("mix", 18, 32'b101010101101010001,
          32'b000101010000101000,
          32'b000100010000100000,
          32'b0);
`ifdef MOORE_MATCH_COUNT_EN
      n_chk++;
      assert (mc_ov === 16'd5) else begin
         n_fail++;
         $error("FAIL cnt_ov: observed %0d expected 5", mc_ov);
      end
      n_chk++;
      assert (mc_no === 16'd3) else begin
         n_fail++;
         $error("FAIL cnt_no: observed %0d expected 3", mc_no);
      end
`endif

      do_reset(1);
      run("mid", 3, 32'b101, 32'b0, 32'b0, 32'b0);
      do_reset(1);
      run("post", 5, 32'b01010,
          32'b00001, 32'b00001, 32'b0);

      do_reset(1);
      run("ones", 6, 32'b111110,
          32'b0, 32'b0, 32'b001110);

      do_reset(1);
      run("near", 9, 32'b110010011, 32'b0, 32'b0, 32'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
